adam_apb_axil_bridge: RTL and testbench
=======================================

Name: adam_apb_axil_bridge

Overview:
APB-slave to AXI-Lite-master bridge, the reverse direction of the AXI-Lite to APB bridge. It lets an APB requester (e.g. a debug or config APB segment) reach the AXI-Lite fabric.
- Each APB access becomes exactly one AXI-Lite read or write. The APB access phase stalls (pready low) until the AXI response returns.
- It implements the ADAM pause protocol, so the block can be clock- or power-gated safely between transactions.

Parameters:
ADAM_CFG_PARAMS, (codebase cfg), supplies ADDR_WIDTH, DATA_WIDTH and the types ADDR_T, DATA_T, STRB_T, PROT_T
ADDR_OFFSET, 0, added to paddr to form the AXI-Lite address (modulo 2^ADDR_WIDTH)

Ports:
seq.clk  in  1  clock (ADAM_SEQ.Slave seq)
seq.rst  in  1  reset, asynchronous, active-high
pause.req  in  1  pause request (ADAM_PAUSE.Slave)
pause.ack  out  1  pause acknowledge
apb.paddr/pprot/psel/penable/pwrite/pwdata/pstrb  in  ADDR_WIDTH/3/1/1/1/DATA_WIDTH/DATA_WIDTH/8  APB request (APB.Slave apb)
apb.pready/prdata/pslverr  out  1/DATA_WIDTH/1  APB response
axil.aw_addr/aw_prot/aw_valid, axil.aw_ready  out/in  ADDR_WIDTH/3/1, 1  write address channel (AXI_LITE.Master axil)
axil.w_data/w_strb/w_valid, axil.w_ready  out/in  DATA_WIDTH/DATA_WIDTH/8/1, 1  write data channel
axil.b_resp/b_valid in, axil.b_ready out  2/1, 1  write response channel
axil.ar_addr/ar_prot/ar_valid, axil.ar_ready  out/in  ADDR_WIDTH/3/1, 1  read address channel
axil.r_data/r_resp/r_valid in, axil.r_ready out  DATA_WIDTH/2/1, 1  read data channel

Behaviour:
- All outputs are registered. On seq.rst=1, asynchronously:
  - FSM enters PAUSED; pause.ack=1.
  - pready, pslverr and all AXI valid/ready outputs = 0; prdata, addr, data and strb = 0.
- Any outstanding AXI transaction is abandoned (system reset covers both ends).
- FSM states: PAUSED, IDLE, WR (AW+W issue), BW (wait B), RD (AR issue), RW (wait R), DONE.
- PAUSED: ack=1. When pause.req=0: ack<=0, go to IDLE. APB accesses seen while paused stall with pready=0.
- IDLE:
  - If pause.req=1, go to PAUSED (ack<=1 next cycle). Pause takes priority over a same-cycle access.
  - Otherwise, on psel=1 & penable=1, capture the access:
    - addr = paddr+ADDR_OFFSET; prot = pprot; wdata = pwdata; strb = pstrb.
    - pwrite=1: assert aw_valid and w_valid, go to WR.
    - pwrite=0: assert ar_valid, go to RD.
- WR:
  - aw_valid and w_valid each drop independently, the cycle after their own handshake; either order or simultaneous is legal.
  - When both handshakes are done, go to BW with b_ready=1.
- BW: on b_valid, go to DONE with pslverr = (b_resp != 2'b00), prdata=0, b_ready<=0.
- RD: hold ar_valid until ar_ready, then go to RW with r_ready=1.
- RW: on r_valid, go to DONE with prdata=r_data, pslverr=(r_resp != 2'b00), r_ready<=0.
  - prdata is returned on an error response too.
- DONE: pready=1 for exactly one cycle, then return to IDLE; pready<=0, pslverr<=0.
  - pause.req is not sampled here; it is handled in IDLE.
  - The APB requester must drop penable after pready, so no double-capture occurs.
- Stability: AXI payloads are stable while the matching valid is high. Valid never drops before its handshake.
- Minimum latency with AXI ready/response immediate (cycle 0 = first access-phase cycle):
  - Write: aw/w valid at cycle 1, b_ready at 2, pready at cycle 3.
  - Read: ar_valid at 1, r_ready at 2, pready at 3.
- pause.req rising during any non-IDLE state: the transaction completes fully before PAUSED is entered.
- psel dropping mid-transaction is an APB violation. The AXI transaction still completes, the DONE pulse is still emitted, then the FSM goes to IDLE.
- Address addition wraps modulo 2^ADDR_WIDTH.
- Exactly one outstanding AXI transaction at any time.

Test Plan:
- Reset release, pause.req=0: ack=1 during reset and drops 1 cycle after. Then write paddr=0x10, pwdata=0xDEADBEEF, pstrb=0xF, ADDR_OFFSET=0x4000_0000 -> aw_addr=0x4000_0010, w_data=0xDEADBEEF, pready at cycle 3, pslverr=0.
- Read with ar_ready delayed 4 cycles and r_valid delayed 2 more, r_data=0x12345678, r_resp=OKAY -> ar_valid held steady, prdata=0x12345678, single pready pulse, pslverr=0.
- Write with w_ready 3 cycles before aw_ready, b_resp=SLVERR -> w_valid drops first, aw_valid holds, pready with pslverr=1. Repeat with b_resp=DECERR -> pslverr=1.
- pause.req asserted mid-read -> read completes normally, ack=1 two cycles after pready. A new APB access while paused stalls with pready=0 and no AXI valid; it completes after pause.req=0.
- seq.rst asserted while in BW -> b_ready, pready and valids go to 0 asynchronously, ack=1. After release, a fresh read completes correctly.
- paddr=0xFFFF_FFF0 with ADDR_OFFSET=0x20 (32-bit) -> ar_addr=0x0000_0010.

Source files
------------

// File: rtl/adam_apb_axil_bridge_if.sv
// Bus bundle for the APB-to-AXI-Lite bridge.
// The "slave" modport is the bridge's view: it is the slave on the APB side
// and the master on the AXI-Lite side. The "master" modport is the view of
// everything around it: the APB requester plus the AXI-Lite target.
interface adam_apb_axil_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // APB
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [2:0]              pprot;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    // AXI-Lite
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]              aw_prot;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]              ar_prot;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport slave (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr,
        output aw_addr, aw_prot, aw_valid, input aw_ready,
        output w_data, w_strb, w_valid, input w_ready,
        input  b_resp, b_valid, output b_ready,
        output ar_addr, ar_prot, ar_valid, input ar_ready,
        input  r_data, r_resp, r_valid, output r_ready
    );

    modport master (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr,
        input  aw_addr, aw_prot, aw_valid, output aw_ready,
        input  w_data, w_strb, w_valid, output w_ready,
        output b_resp, b_valid, input b_ready,
        input  ar_addr, ar_prot, ar_valid, output ar_ready,
        output r_data, r_resp, r_valid, input r_ready
    );
endinterface

// File: rtl/adam_apb_axil_bridge.sv
// APB slave to AXI-Lite master bridge with pause handshake.
// Each APB access becomes exactly one AXI-Lite transaction; the APB access
// phase is stalled until the AXI response returns. All outputs registered.
//
// state  | meaning
// -------+-----------------------------------------------------------
// PAUSED | gated, pause_ack high, APB accesses stall
// IDLE   | waiting for an APB access phase (or a pause request)
// WR     | aw_valid / w_valid issued, each drops after its handshake
// BW     | waiting for write response, b_ready high
// RD     | ar_valid issued, waiting for ar_ready
// RW     | waiting for read data, r_ready high
// DONE   | one-cycle pready pulse back to the APB requester
module adam_apb_axil_bridge #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR_OFFSET = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pause_req_i,
    output logic                  pause_ack_o,
    adam_apb_axil_bridge_if.slave bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_PAUSED, S_IDLE, S_WR, S_BW, S_RD, S_RW, S_DONE
    } state_t;

    state_t                  state_q,    state_d;
    logic                    ack_q,      ack_d;
    logic                    pready_q,   pready_d;
    logic                    pslverr_q,  pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q,   prdata_d;
    logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
    logic [2:0]              prot_q,     prot_d;
    logic [DATA_WIDTH-1:0]   wdata_q,    wdata_d;
    logic [STRB_WIDTH-1:0]   strb_q,     strb_d;
    logic                    aw_valid_q, aw_valid_d;
    logic                    w_valid_q,  w_valid_d;
    logic                    b_ready_q,  b_ready_d;
    logic                    ar_valid_q, ar_valid_d;
    logic                    r_ready_q,  r_ready_d;

    logic access;
    logic aw_left;
    logic w_left;

    assign access  = bus.psel && bus.penable;
    // A write channel is still pending if its valid is up and not accepted now.
    assign aw_left = aw_valid_q && !bus.aw_ready;
    assign w_left  = w_valid_q  && !bus.w_ready;

    // State and registered outputs; reset abandons any outstanding transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_PAUSED;
            ack_q      <= 1'b1;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            addr_q     <= '0;
            prot_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
            addr_q     <= addr_d;
            prot_q     <= prot_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            b_ready_q  <= b_ready_d;
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= r_ready_d;
        end
    end

    // Next-state decision; pause wins over a same-cycle access in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PAUSED: if (!pause_req_i) state_d = S_IDLE;
            S_IDLE: begin
                if (pause_req_i)  state_d = S_PAUSED;
                else if (access)  state_d = bus.pwrite ? S_WR : S_RD;
            end
            S_WR:   if (!aw_left && !w_left) state_d = S_BW;
            S_BW:   if (bus.b_valid)  state_d = S_DONE;
            S_RD:   if (bus.ar_ready) state_d = S_RW;
            S_RW:   if (bus.r_valid)  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_PAUSED;
        endcase
    end

    // Next values of the registered outputs and captured request.
    always_comb begin
        ack_d      = ack_q;
        pready_d   = pready_q;
        pslverr_d  = pslverr_q;
        prdata_d   = prdata_q;
        addr_d     = addr_q;
        prot_d     = prot_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        b_ready_d  = b_ready_q;
        ar_valid_d = ar_valid_q;
        r_ready_d  = r_ready_q;
        case (state_q)
            S_PAUSED: if (!pause_req_i) ack_d = 1'b0;
            S_IDLE: begin
                if (pause_req_i) begin
                    ack_d = 1'b1;
                end else if (access) begin
                    addr_d  = bus.paddr + ADDR_OFFSET;
                    prot_d  = bus.pprot;
                    wdata_d = bus.pwdata;
                    strb_d  = bus.pstrb;
                    if (bus.pwrite) begin
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        ar_valid_d = 1'b1;
                    end
                end
            end
            S_WR: begin
                aw_valid_d = aw_left;
                w_valid_d  = w_left;
                if (!aw_left && !w_left) b_ready_d = 1'b1;
            end
            S_BW: begin
                if (bus.b_valid) begin
                    b_ready_d = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = (bus.b_resp != 2'b00);
                    prdata_d  = '0;
                end
            end
            S_RD: begin
                if (bus.ar_ready) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                end
            end
            S_RW: begin
                if (bus.r_valid) begin
                    r_ready_d = 1'b0;
                    pready_d  = 1'b1;
                    pslverr_d = (bus.r_resp != 2'b00);
                    prdata_d  = bus.r_data;
                end
            end
            S_DONE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign pause_ack_o  = ack_q;
    assign bus.pready   = pready_q;
    assign bus.pslverr  = pslverr_q;
    assign bus.prdata   = prdata_q;
    assign bus.aw_addr  = addr_q;
    assign bus.aw_prot  = prot_q;
    assign bus.aw_valid = aw_valid_q;
    assign bus.w_data   = wdata_q;
    assign bus.w_strb   = strb_q;
    assign bus.w_valid  = w_valid_q;
    assign bus.b_ready  = b_ready_q;
    assign bus.ar_addr  = addr_q;
    assign bus.ar_prot  = prot_q;
    assign bus.ar_valid = ar_valid_q;
    assign bus.r_ready  = r_ready_q;
endmodule

// File: tb/tb_adam_apb_axil_bridge.sv
// Directed + randomized bench for the APB-to-AXI-Lite bridge.
// A second instance with a small offset covers address wrap-around.
module tb_adam_apb_axil_bridge;
    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam logic [31:0] OFS  = 32'h4000_0000;
    localparam logic [31:0] OFS2 = 32'h0000_0020;
    localparam int          TMO  = 80;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pause_req  = 1'b0;
    logic pause_ack;
    logic pause_req2 = 1'b0;
    logic pause_ack2;

    int errors = 0;
    int checks = 0;

    adam_apb_axil_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
    adam_apb_axil_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

    adam_apb_axil_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_OFFSET(OFS)) dut (
        .clk_i(clk), .rst_i(rst), .pause_req_i(pause_req), .pause_ack_o(pause_ack), .bus(bus)
    );
    adam_apb_axil_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_OFFSET(OFS2)) dut2 (
        .clk_i(clk), .rst_i(rst), .pause_req_i(pause_req2), .pause_ack_o(pause_ack2), .bus(bus2)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference rules: address offset modulo 2^32, error on any non-OKAY
    // response, latency = issue + address phase + response phase.
    function automatic logic [31:0] exp_addr(input logic [31:0] a, input logic [31:0] ofs);
        return a + ofs;
    endfunction

    function automatic int wr_latency(input int aw_d, input int w_d, input int b_d);
        return 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d;
    endfunction

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot,
                            output logic [31:0] rdata, output logic slverr, output int lat);
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
        bus.paddr = addr; bus.pwdata = wdata; bus.pstrb = strb; bus.pprot = prot;
        @(negedge clk);
        bus.penable = 1'b1;
        lat = 0;
        while (bus.pready !== 1'b1 && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        chk("apb_timeout", (lat < TMO), 1);
        rdata  = bus.prdata;
        slverr = bus.pslverr;
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge clk);
        chk("pready_pulse", bus.pready, 0);
    endtask

    task automatic axi_wr(input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] resp,
                          output logic [31:0] addr, output logic [31:0] data,
                          output logic [3:0] strb, output logic [2:0] prot);
        int  c;
        bit  aw_done;
        bit  w_done;
        c = 0;
        @(negedge clk);
        while (bus.aw_valid !== 1'b1 && c < TMO) begin
            chk("no_ar_on_write", bus.ar_valid, 0);
            @(negedge clk);
            c++;
        end
        chk("aw_wait", (c < TMO), 1);
        chk("w_valid_with_aw", bus.w_valid, 1);
        addr = bus.aw_addr; data = bus.w_data; strb = bus.w_strb; prot = bus.aw_prot;
        aw_done = 0; w_done = 0; c = 0;
        while (!(aw_done && w_done) && c < TMO) begin
            chk("aw_valid", bus.aw_valid, !aw_done);
            chk("w_valid", bus.w_valid, !w_done);
            if (!aw_done) chk("aw_addr_stable", bus.aw_addr, addr);
            if (!w_done)  chk("w_data_stable", bus.w_data, data);
            chk("b_ready_early", bus.b_ready, 0);
            bus.aw_ready = (!aw_done && c >= aw_dly);
            bus.w_ready  = (!w_done && c >= w_dly);
            if (bus.aw_ready) aw_done = 1;
            if (bus.w_ready)  w_done = 1;
            @(negedge clk);
            c++;
        end
        bus.aw_ready = 1'b0; bus.w_ready = 1'b0;
        chk("wr_hs_timeout", (aw_done && w_done), 1);
        chk("aw_valid_drop", bus.aw_valid, 0);
        chk("w_valid_drop", bus.w_valid, 0);
        chk("b_ready_up", bus.b_ready, 1);
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            chk("b_ready_hold", bus.b_ready, 1);
        end
        bus.b_valid = 1'b1; bus.b_resp = resp;
        @(negedge clk);
        bus.b_valid = 1'b0; bus.b_resp = 2'b00;
        chk("b_ready_drop", bus.b_ready, 0);
    endtask

    task automatic axi_rd(input int ar_dly, input int r_dly, input logic [31:0] rdata,
                          input logic [1:0] resp, output logic [31:0] addr, output logic [2:0] prot);
        int c;
        c = 0;
        @(negedge clk);
        while (bus.ar_valid !== 1'b1 && c < TMO) begin
            @(negedge clk);
            c++;
        end
        chk("ar_wait", (c < TMO), 1);
        addr = bus.ar_addr; prot = bus.ar_prot;
        for (int i = 0; i < ar_dly; i++) begin
            chk("ar_valid_hold", bus.ar_valid, 1);
            chk("ar_addr_stable", bus.ar_addr, addr);
            chk("no_aw_on_read", bus.aw_valid, 0);
            chk("r_ready_early", bus.r_ready, 0);
            @(negedge clk);
        end
        bus.ar_ready = 1'b1;
        @(negedge clk);
        bus.ar_ready = 1'b0;
        chk("ar_valid_drop", bus.ar_valid, 0);
        chk("r_ready_up", bus.r_ready, 1);
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            chk("r_ready_hold", bus.r_ready, 1);
        end
        bus.r_valid = 1'b1; bus.r_data = rdata; bus.r_resp = resp;
        @(negedge clk);
        bus.r_valid = 1'b0; bus.r_data = '0; bus.r_resp = 2'b00;
        chk("r_ready_drop", bus.r_ready, 0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [2:0] prot, input int aw_d, input int w_d, input int b_d,
                            input logic [1:0] resp);
        logic [31:0] got_addr, got_data, rd;
        logic [3:0]  got_strb;
        logic [2:0]  got_prot;
        logic        err;
        int          lat;
        fork
            apb_xfer(1'b1, addr, data, strb, prot, rd, err, lat);
            axi_wr(aw_d, w_d, b_d, resp, got_addr, got_data, got_strb, got_prot);
        join
        chk("wr_aw_addr", got_addr, exp_addr(addr, OFS));
        chk("wr_w_data", got_data, data);
        chk("wr_w_strb", got_strb, strb);
        chk("wr_aw_prot", got_prot, prot);
        chk("wr_pslverr", err, (resp != 2'b00));
        chk("wr_prdata", rd, 0);
        chk("wr_latency", lat, wr_latency(aw_d, w_d, b_d));
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] prot, input logic [31:0] data,
                           input logic [1:0] resp, input int ar_d, input int r_d);
        logic [31:0] got_addr, rd;
        logic [2:0]  got_prot;
        logic        err;
        int          lat;
        fork
            apb_xfer(1'b0, addr, 32'h0, 4'h0, prot, rd, err, lat);
            axi_rd(ar_d, r_d, data, resp, got_addr, got_prot);
        join
        chk("rd_ar_addr", got_addr, exp_addr(addr, OFS));
        chk("rd_ar_prot", got_prot, prot);
        chk("rd_prdata", rd, data);
        chk("rd_pslverr", err, (resp != 2'b00));
        chk("rd_latency", lat, 3 + ar_d + r_d);
    endtask

    initial begin
        logic [31:0] a, d, rd, got_addr, got_data;
        logic [3:0]  s, got_strb;
        logic [2:0]  p, got_prot;
        logic        err;
        int          lat, c;

        bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0;
        bus.pwdata = 0; bus.pstrb = 0; bus.pprot = 0;
        bus.aw_ready = 0; bus.w_ready = 0; bus.b_valid = 0; bus.b_resp = 0;
        bus.ar_ready = 0; bus.r_valid = 0; bus.r_data = 0; bus.r_resp = 0;
        bus2.psel = 0; bus2.penable = 0; bus2.pwrite = 0; bus2.paddr = 0;
        bus2.pwdata = 0; bus2.pstrb = 0; bus2.pprot = 0;
        bus2.aw_ready = 1; bus2.w_ready = 1; bus2.b_valid = 1; bus2.b_resp = 0;
        bus2.ar_ready = 1; bus2.r_valid = 1; bus2.r_data = 32'hA5A5_5A5A; bus2.r_resp = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", pause_ack, 1);
        chk("rst_pready", bus.pready, 0);
        chk("rst_pslverr", bus.pslverr, 0);
        chk("rst_prdata", bus.prdata, 0);
        chk("rst_aw_valid", bus.aw_valid, 0);
        chk("rst_w_valid", bus.w_valid, 0);
        chk("rst_ar_valid", bus.ar_valid, 0);
        chk("rst_b_ready", bus.b_ready, 0);
        chk("rst_r_ready", bus.r_ready, 0);
        chk("rst_addr", bus.aw_addr, 0);
        chk("rst_wdata", bus.w_data, 0);
        chk("rst_strb", bus.w_strb, 0);
        rst = 1'b0;
        #1;
        chk("ack_after_release", pause_ack, 1);
        @(negedge clk);
        chk("ack_drop", pause_ack, 0);
        chk("ack2_drop", pause_ack2, 0);

        // Minimum-latency write
        do_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 0, 0, 2'b00);
        // Slow read
        do_read(32'h0000_0100, 3'b010, 32'h1234_5678, 2'b00, 4, 2);
        // W before AW with error responses
        do_write(32'h0000_0200, 32'hCAFE_F00D, 4'hF, 3'b001, 3, 0, 0, 2'b10);
        do_write(32'h0000_0204, 32'h0BAD_F00D, 4'h3, 3'b001, 3, 0, 1, 2'b11);
        // Read error still returns data
        do_read(32'h0000_0300, 3'b100, 32'h8765_4321, 2'b10, 0, 0);

        // Pause rising mid-read
        fork
            do_read(32'h0000_0400, 3'b000, 32'h5555_AAAA, 2'b00, 2, 2);
            begin
                repeat (4) @(negedge clk);
                pause_req = 1'b1;
            end
        join
        chk("ack_not_yet", pause_ack, 0);
        @(negedge clk);
        chk("ack_after_done", pause_ack, 1);

        // Access while paused stalls until pause released
        fork
            apb_xfer(1'b1, 32'h0000_0500, 32'h0F0F_0F0F, 4'hA, 3'b011, rd, err, lat);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("paused_pready", bus.pready, 0);
                    chk("paused_aw", bus.aw_valid, 0);
                    chk("paused_ar", bus.ar_valid, 0);
                    chk("paused_ack", pause_ack, 1);
                end
                pause_req = 1'b0;
                axi_wr(0, 0, 0, 2'b00, got_addr, got_data, got_strb, got_prot);
            end
        join
        chk("paused_wr_addr", got_addr, exp_addr(32'h0000_0500, OFS));
        chk("paused_wr_data", got_data, 32'h0F0F_0F0F);
        chk("paused_wr_strb", got_strb, 4'hA);
        chk("paused_wr_err", err, 0);
        chk("paused_stalled", (lat > 5), 1);

        // Randomized transactions
        for (int n = 0; n < 20; n++) begin
            a = $urandom;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            p = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
                do_write(a, d, s, p, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), 2'($urandom_range(0, 3)));
            else
                do_read(a, p, d, 2'($urandom_range(0, 3)), $urandom_range(0, 3),
                        $urandom_range(0, 3));
        end

        // Reset while waiting for B
        @(negedge clk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 32'h0000_0600; bus.pwdata = 32'h1111_2222; bus.pstrb = 4'hF;
        bus.aw_ready = 1'b1; bus.w_ready = 1'b1;
        @(negedge clk);
        bus.penable = 1'b1;
        c = 0;
        while (bus.b_ready !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("reach_bw", bus.b_ready, 1);
        rst = 1'b1;
        #1;
        chk("arst_b_ready", bus.b_ready, 0);
        chk("arst_pready", bus.pready, 0);
        chk("arst_aw_valid", bus.aw_valid, 0);
        chk("arst_w_valid", bus.w_valid, 0);
        chk("arst_ar_valid", bus.ar_valid, 0);
        chk("arst_ack", pause_ack, 1);
        bus.psel = 1'b0; bus.penable = 1'b0; bus.aw_ready = 1'b0; bus.w_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ack_drop2", pause_ack, 0);
        do_read(32'h0000_0700, 3'b000, 32'h9ABC_DEF0, 2'b00, 1, 1);

        // Address wrap on the small-offset instance
        @(negedge clk);
        bus2.psel = 1'b1; bus2.penable = 1'b0; bus2.pwrite = 1'b0; bus2.paddr = 32'hFFFF_FFF0;
        @(negedge clk);
        bus2.penable = 1'b1;
        c = 0;
        while (bus2.ar_valid !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("wrap_ar_seen", bus2.ar_valid, 1);
        chk("wrap_ar_addr", bus2.ar_addr, exp_addr(32'hFFFF_FFF0, OFS2));
        chk("wrap_ar_addr_lit", bus2.ar_addr, 32'h0000_0010);
        c = 0;
        while (bus2.pready !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("wrap_pready", bus2.pready, 1);
        chk("wrap_prdata", bus2.prdata, 32'hA5A5_5A5A);
        chk("wrap_pslverr", bus2.pslverr, 0);
        bus2.psel = 1'b0; bus2.penable = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
